dynode_baseline: RTL

DYNODE_BASELINE -- requirements
Module: dynode_baseline

---
 rtl/dynode_pkg.sv | 13 +
 rtl/dynode_baseline.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dynode_pkg.sv
// rtl/dynode_pkg.sv - shared ADC width and state codes for the dynode baseline tracker
package dynode_pkg;

    // Raw dynode ADC sample width
    localparam int ADC_W = 12;

    // Baseline tracker state codes, also exported on bl_state
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

endpackage

// File: rtl/dynode_baseline.sv
// rtl/dynode_baseline.sv - dynode ADC baseline estimator with event hold and holdoff
module dynode_baseline
    import dynode_pkg::*;
#(
    parameter int               AVG_SHIFT = 6,
    parameter int               HOLDOFF   = 16,
    parameter logic [ADC_W-1:0] THRESH    = 12'd64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_in,
    input  logic             dyn_indet,
    output logic [ADC_W-1:0] dyn_blcor,
    output logic [ADC_W-1:0] baseline,
    output logic             bl_valid,
    output logic [1:0]       bl_state
);

    // acc holds baseline * 2^AVG_SHIFT; its fixed point for a full-scale
    // input is 4095 * 2^AVG_SHIFT, which still fits in ACC_W bits.
    localparam int ACC_W = ADC_W + AVG_SHIFT;
    localparam int HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);

    logic [1:0]           state;
    logic [1:0]           state_nx;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     init_sum;
    logic [ACC_W-1:0]     acc_upd;
    logic [AVG_SHIFT-1:0] init_cnt;
    logic                 init_last;
    logic [HO_W-1:0]      ho_cnt;
    logic [ADC_W:0]       exc_limit;
    logic                 excursion;
    logic                 hold_req;
    logic                 acc_update;
    logic                 init_done;

    assign bl_state = state;

    // Excursion limit is formed one bit wider so baseline + THRESH cannot wrap
    assign exc_limit = {1'b0, baseline} + {1'b0, THRESH};
    assign excursion = {1'b0, adc_in} > exc_limit;
    assign hold_req  = dyn_indet || excursion;

    // The counter wrapping from all-ones is the last INIT sample
    assign init_last = &init_cnt;
    assign init_done = (state == ST_INIT) && init_last;
    assign init_sum  = acc + ACC_W'(adc_in);

    // Leaky average: acc - acc/2^N never goes negative, and adding one
    // sample cannot exceed the full-scale fixed point, so no extra bits
    assign acc_upd    = acc - (acc >> AVG_SHIFT) + ACC_W'(adc_in);
    assign acc_update = (state == ST_TRACK) && !hold_req;

    // Next-state selection; an event always wins over holdoff expiry
    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT: begin
                if (init_last) begin
                    state_nx = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (hold_req) begin
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!hold_req) begin
                    state_nx = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_req) begin
                    state_nx = ST_HOLD;
                end else if (ho_cnt == '0) begin
                    state_nx = ST_TRACK;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // INIT sample counter, runs only while the initial average is gathered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + AVG_SHIFT'(1);
        end
    end

    // Accumulator: plain sum during INIT, leaky average while tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (state == ST_INIT) begin
            acc <= init_sum;
        end else if (acc_update) begin
            acc <= acc_upd;
        end
    end

    // Baseline follows the accumulator's integer part; frozen in HOLD/HOLDOFF
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baseline <= '0;
        end else if (init_done) begin
            baseline <= init_sum[ACC_W-1:AVG_SHIFT];
        end else if (acc_update) begin
            baseline <= acc_upd[ACC_W-1:AVG_SHIFT];
        end
    end

    // Baseline-valid flag is sticky until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bl_valid <= 1'b0;
        end else if (init_done) begin
            bl_valid <= 1'b1;
        end
    end

    // Holdoff counter: full reload on every HOLD exit, counts down in HOLDOFF
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ho_cnt <= '0;
        end else if ((state == ST_HOLD) && !hold_req) begin
            ho_cnt <= HO_LOAD;
        end else if ((state == ST_HOLDOFF) && !hold_req && (ho_cnt != '0)) begin
            ho_cnt <= ho_cnt - HO_W'(1);
        end
    end

    // Corrected sample: adc minus baseline, clamped at zero, muted until valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dyn_blcor <= '0;
        end else if (!bl_valid) begin
            dyn_blcor <= '0;
        end else if (adc_in > baseline) begin
            dyn_blcor <= adc_in - baseline;
        end else begin
            dyn_blcor <= '0;
        end
    end

endmodule
